data_stack: RTL and testbench

Operand stack that sits directly downstream of the control unit. It consumes the control unit's `stackOP` code and the datapath write value, and presents registered top-of-stack and next-of-stack values to the ALU, memory and branch logic. The top two entries are held in registers; deeper entries spill into an internal array addressed by a depth counter.

---
 rtl/data_stack.sv | 173 +++++++++++++++++
 tb/tb_data_stack.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// ============================================================================
//  Module      : data_stack
//  Description : Operand stack with the top two entries held in registers and
//                deeper entries spilled into an internal circular array.
//                Optional guard checking is enabled by defining the macro
//                DSTACK_GUARD_EN (suppresses illegal ops, sets sticky flags).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [2:0]               stackOP,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         top,
  output logic [WIDTH-1:0]         next,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] C_DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE       = (AW+1)'(1);
  localparam logic [AW:0] C_TWO       = (AW+1)'(2);
  localparam logic [AW:0] C_THREE     = (AW+1)'(3);
  localparam logic [AW:0] C_FOUR      = (AW+1)'(4);

  localparam logic [2:0] C_OP_PUSH = 3'd1;
  localparam logic [2:0] C_OP_BIN  = 3'd2;
  localparam logic [2:0] C_OP_POP  = 3'd3;
  localparam logic [2:0] C_OP_POP2 = 3'd4;
  localparam logic [2:0] C_OP_SWAP = 3'd5;

  logic [WIDTH-1:0] r_top, r_next;
  logic [AW:0]      r_depth;
  // Logical array entry i lives at physical slot r_base + i; r_base only moves
  // when a push at full discards the oldest entry, avoiding a physical shift.
  logic [AW-1:0]    r_base;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_top_n, w_next_n;
  logic [AW:0]      w_depth_n;
  logic [AW-1:0]    w_base_n;
  logic             w_we;
  logic             w_block;
  logic             w_full;
  logic [AW-1:0]    w_wr_idx, w_rd3_idx, w_rd4_idx;
  logic [WIDTH-1:0] w_arr3, w_arr4;

  assign w_full    = (r_depth == C_DEPTH_MAX);
  assign w_wr_idx  = r_base + r_depth[AW-1:0] - AW'(2);
  assign w_rd3_idx = r_base + r_depth[AW-1:0] - AW'(3);
  assign w_rd4_idx = r_base + r_depth[AW-1:0] - AW'(4);
  // Array slots above the live region are stale; only read entries that exist
  assign w_arr3    = (r_depth >= C_THREE) ? r_mem[w_rd3_idx] : '0;
  assign w_arr4    = (r_depth >= C_FOUR)  ? r_mem[w_rd4_idx] : '0;

  // Next-state computation; missing entries read as zero, depth saturates at 0
  always_comb begin
    w_top_n   = r_top;
    w_next_n  = r_next;
    w_depth_n = r_depth;
    w_base_n  = r_base;
    w_we      = 1'b0;
    case (stackOP)
      C_OP_PUSH: begin
        w_top_n  = wdata;
        w_next_n = r_top;
        w_we     = (r_depth >= C_TWO);
        if (w_full) w_base_n  = r_base + AW'(1);
        else        w_depth_n = r_depth + C_ONE;
      end
      C_OP_BIN: begin
        w_top_n   = wdata;
        w_next_n  = w_arr3;
        w_depth_n = (r_depth >= C_ONE) ? r_depth - C_ONE : '0;
      end
      C_OP_POP: begin
        w_top_n   = r_next;
        w_next_n  = w_arr3;
        w_depth_n = (r_depth >= C_ONE) ? r_depth - C_ONE : '0;
      end
      C_OP_POP2: begin
        w_top_n   = w_arr3;
        w_next_n  = w_arr4;
        w_depth_n = (r_depth >= C_TWO) ? r_depth - C_TWO : '0;
      end
      C_OP_SWAP: begin
        w_top_n  = r_next;
        w_next_n = r_top;
      end
      default: ;
    endcase
    // Registers for absent entries always hold zero
    if (w_depth_n == '0)  w_top_n  = '0;
    if (w_depth_n < C_TWO) w_next_n = '0;
  end

`ifdef DSTACK_GUARD_EN
  logic [AW:0] w_req;
  logic        w_under, w_over;
  logic        r_ovf, r_unf;

  // Minimum number of entries each opcode needs before it may execute
  always_comb begin
    w_req = '0;
    case (stackOP)
      C_OP_BIN, C_OP_POP2, C_OP_SWAP: w_req = C_TWO;
      C_OP_POP:                       w_req = C_ONE;
      default:                        w_req = '0;
    endcase
  end

  assign w_under = (r_depth < w_req);
  assign w_over  = (stackOP == C_OP_PUSH) && w_full;
  assign w_block = w_under | w_over;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_over)  r_ovf <= 1'b1;
      if (w_under) r_unf <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  assign w_block   = 1'b0;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // Top/next/depth state; a blocked op leaves everything unchanged
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_top   <= '0;
      r_next  <= '0;
      r_depth <= '0;
      r_base  <= '0;
    end else if (!w_block) begin
      r_top   <= w_top_n;
      r_next  <= w_next_n;
      r_depth <= w_depth_n;
      r_base  <= w_base_n;
    end
  end

  // Spill the old next into the array on push; contents are never reset
  always_ff @(posedge CLK) begin
    if (w_we && !w_block) r_mem[w_wr_idx] <= r_next;
  end

  assign top   = r_top;
  assign next  = r_next;
  assign depth = r_depth;
  assign empty = (r_depth == '0);
  assign full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_data_stack.sv
// ============================================================================
//  Module      : tb_data_stack
//  Description : Scoreboard bench for data_stack. Build with DSTACK_GUARD_EN
//                defined to exercise the guarded variant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int DW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nxt;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
  } obs_t;

  logic             CLK;
  logic             reset;
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] top, next;
  logic [DW-1:0]    depth;
  logic             empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  obs_t expq[$];

  // Reference model: plain queue, bottom of stack at index 0
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf, m_unf;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .stackOP(stackOP), .wdata(wdata),
    .top(top), .next(next), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic obs_t model_obs();
    obs_t o;
    int n = mq.size();
    o.top   = (n > 0) ? mq[n-1] : '0;
    o.nxt   = (n > 1) ? mq[n-2] : '0;
    o.depth = DW'(n);
    o.empty = (n == 0);
    o.full  = (n == DEPTH);
    o.ovf   = m_ovf;
    o.unf   = m_unf;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.top = top; o.nxt = next; o.depth = depth;
    o.empty = empty; o.full = full; o.ovf = overflow; o.unf = underflow;
    return o;
  endfunction

  task automatic model_step(input logic [2:0] op, input logic [WIDTH-1:0] w);
    int d = mq.size();
    logic [WIDTH-1:0] a, b;
    case (op)
      3'd1: begin
        if (d == DEPTH) begin
`ifdef DSTACK_GUARD_EN
          m_ovf = 1'b1;
`else
          void'(mq.pop_front());
          mq.push_back(w);
`endif
        end else mq.push_back(w);
      end
      3'd2: begin
        if (d < 2) begin
`ifdef DSTACK_GUARD_EN
          m_unf = 1'b1;
`else
          mq.delete();
`endif
        end else begin
          void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(w);
        end
      end
      3'd3: begin
        if (d < 1) begin
`ifdef DSTACK_GUARD_EN
          m_unf = 1'b1;
`endif
        end else void'(mq.pop_back());
      end
      3'd4: begin
        if (d < 2) begin
`ifdef DSTACK_GUARD_EN
          m_unf = 1'b1;
`else
          mq.delete();
`endif
        end else begin
          void'(mq.pop_back()); void'(mq.pop_back());
        end
      end
      3'd5: begin
        if (d < 2) begin
`ifdef DSTACK_GUARD_EN
          m_unf = 1'b1;
`endif
        end else begin
          a = mq.pop_back(); b = mq.pop_back();
          mq.push_back(a); mq.push_back(b);
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got top=%h next=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, expected top=%h next=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
               name, act.top, act.nxt, act.depth, act.empty, act.full, act.ovf, act.unf,
               exp.top, exp.nxt, exp.depth, exp.empty, exp.full, exp.ovf, exp.unf);
    end
  endtask

  // Issue one op on the falling edge and queue the state expected after the next rising edge
  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] w);
    @(negedge CLK);
    stackOP = op;
    wdata   = w;
    model_step(op, w);
    expq.push_back(model_obs());
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Monitor: compare one queued expectation after every rising edge that has one
  initial begin
    obs_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        compare("op_result", dut_obs(), e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    model_reset();
    stackOP = 3'd0;
    wdata   = '0;
    reset   = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    compare("reset_state", dut_obs(), model_obs());
    @(negedge CLK);
    reset = 1'b0;

    // Basic push / binary / swap / drain
    do_op(3'd1, 16'h0011); do_op(3'd1, 16'h0022); do_op(3'd1, 16'h0033);
    do_op(3'd2, 16'h0055); do_op(3'd5, 16'h0000);
    do_op(3'd3, 16'h0000); do_op(3'd3, 16'h0000);
    // pop2 reading both entries from the spill array
    do_op(3'd1, 16'hAAAA); do_op(3'd1, 16'hBBBB); do_op(3'd1, 16'hCCCC);
    do_op(3'd1, 16'hDDDD); do_op(3'd4, 16'h0000);
    do_op(3'd3, 16'h0000); do_op(3'd3, 16'h0000);
    // Pop at empty, then push
    do_op(3'd3, 16'h0000); do_op(3'd1, 16'h0001);
    do_op(3'd3, 16'h0000);
    // Fill to full, push past full, reserved ops, deep unwind
    for (int i = 1; i <= DEPTH; i++) do_op(3'd1, WIDTH'(i));
    do_op(3'd1, WIDTH'(33));
    do_op(3'd6, 16'h1234); do_op(3'd7, 16'h5678);
    for (int i = 0; i < DEPTH - 1; i++) do_op(3'd3, 16'h0000);

    // Randomized ops; push-heavy bursts reach full, mixed bursts drain
    for (int i = 0; i < 2000; i++) begin
      if (((i / 200) % 2) == 0 && $urandom_range(0, 2) != 0) op = 3'd1;
      else op = 3'($urandom_range(0, 7));
`ifndef DSTACK_GUARD_EN
      if ((op == 3'd2 || op == 3'd5) && mq.size() < 2) op = 3'd0;
`endif
      do_op(op, WIDTH'($urandom));
    end

    // Asynchronous reset mid-stream
    do_op(3'd1, 16'h0F0F); do_op(3'd1, 16'hF0F0); do_op(3'd1, 16'h1111);
    @(posedge CLK);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    compare("async_reset", dut_obs(), model_obs());
    @(negedge CLK);
    stackOP = 3'd0;
    @(negedge CLK);
    #1;
    reset = 1'b0;
    do_op(3'd3, 16'h0000);
    do_op(3'd1, 16'h4242);
    do_op(3'd0, 16'h0000);
    @(posedge CLK);
    #2;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
